// File: rtl/inst_mem_responder.sv
// Instruction memory responder: preloadable word array with a fixed-latency,
// non-stalling read pipeline. Each request is answered exactly LATENCY cycles
// after it is accepted, and requests can be accepted one per cycle.
module inst_mem_responder #(
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] NOP_INST  = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   output logic [31:0] resp_addr,
   output logic [31:0] resp_inst,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int unsigned AW     = $clog2(MEM_WORDS);
   localparam int unsigned STAGES = LATENCY - 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } stage_t;

   logic [31:0]     mem [MEM_WORDS];
   logic [STAGES:0] vld_pipe;
   stage_t          pipe [STAGES+1];
   stage_t          rd_word;
   logic            accept;
   logic            rd_in_range;
   logic            wr_in_range;
   logic [AW-1:0]   rd_idx;
   logic [AW-1:0]   wr_idx;
   logic            unused_lsbs;

   // Writes win the cycle; nothing is accepted while in reset.
   assign req_ready   = rst_n && !wr_en;
   assign accept      = req_valid && req_ready;

   assign rd_idx      = req_addr[AW+1:2];
   assign wr_idx      = wr_addr[AW+1:2];
   assign rd_in_range = (req_addr[31:AW+2] == '0);
   assign wr_in_range = (wr_addr[31:AW+2] == '0);
   assign unused_lsbs = ^{req_addr[1:0], wr_addr[1:0]};

   // Preload port; contents deliberately survive reset, out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) mem[wr_idx] <= wr_data;
   end

   // Word captured at accept time; out-of-range fetches answer with a NOP.
   always_comb begin
      rd_word.addr = req_addr;
      rd_word.inst = rd_in_range ? mem[rd_idx] : NOP_INST;
   end

   // Read pipeline: valids shift every edge; payload follows its valid so the
   // last stage keeps the previous response while resp_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int k = 0; k <= STAGES; k++) pipe[k] <= '0;
      end else begin
         vld_pipe[0] <= accept;
         if (accept) pipe[0] <= rd_word;
         for (int k = 1; k <= STAGES; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            if (vld_pipe[k-1]) pipe[k] <= pipe[k-1];
         end
      end
   end

   assign resp_valid = vld_pipe[STAGES];
   assign resp_addr  = pipe[STAGES].addr;
   assign resp_inst  = pipe[STAGES].inst;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: three instances (LATENCY 1, 2, 4) share one
// stimulus stream; a scoreboard of accepted requests indexed by edge number
// predicts every output on every falling edge.
module tb_inst_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   logic [2:0]  rdy;
   logic [2:0]  rv;
   logic [31:0] ra [3];
   logic [31:0] ri [3];

   int tests = 0;
   int fails = 0;

   localparam int LATS [3] = '{1, 2, 4};

   always #5 clk = ~clk;

   inst_mem_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
      .resp_valid(rv[0]), .resp_addr(ra[0]), .resp_inst(ri[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
   inst_mem_responder #(.LATENCY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
      .resp_valid(rv[1]), .resp_addr(ra[1]), .resp_inst(ri[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
   inst_mem_responder #(.LATENCY(4)) u4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_addr(req_addr),
      .resp_valid(rv[2]), .resp_addr(ra[2]), .resp_inst(ri[2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (LATENCY=%0d) at %0t: got %h, expected %h", nm, lat, $time, act, exp);
      end
   endtask

   // Scoreboard: what was accepted at each edge, and the word it must return.
   logic [31:0] mmem  [0:4095];
   logic        acc_v [0:1023];
   logic [31:0] acc_a [0:1023];
   logic [31:0] acc_i [0:1023];
   int          ecnt  = 0;
   int          flush = 0;
   logic [31:0] last_a [3] = '{0, 0, 0};
   logic [31:0] last_i [3] = '{0, 0, 0};

   // Record each edge's accept from the array as it stood before that edge.
   always @(posedge clk) begin
      if (ecnt < 1023) begin
         acc_v[ecnt+1] <= rst_n && req_valid && !wr_en;
         acc_a[ecnt+1] <= req_addr;
         acc_i[ecnt+1] <= (req_addr[31:14] == 18'd0) ? mmem[req_addr[13:2]] : 32'h00000013;
      end
      if (wr_en && wr_addr[31:14] == 18'd0) mmem[wr_addr[13:2]] <= wr_data;
      ecnt <= ecnt + 1;
   end

   // Reset kills everything accepted so far and zeroes the held response.
   always @(negedge rst_n) begin
      flush <= ecnt;
      for (int i = 0; i < 3; i++) begin
         last_a[i] <= '0;
         last_i[i] <= '0;
      end
   end

   // Per-cycle compare: response for an accept at edge k is visible after edge k+LAT-1.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int k;
         logic ev;
         logic [31:0] ea, ei;
         k  = ecnt - LATS[i] + 1;
         ev = rst_n && (k >= 1) && (k > flush) && (k < 1024) && acc_v[k];
         ea = !rst_n ? 32'h0 : (ev ? acc_a[k] : last_a[i]);
         ei = !rst_n ? 32'h0 : (ev ? acc_i[k] : last_i[i]);
         last_a[i] <= ea;
         last_i[i] <= ei;
         chk("resp_valid", LATS[i], {31'd0, rv[i]}, {31'd0, ev});
         chk("resp_addr",  LATS[i], ra[i], ea);
         chk("resp_inst",  LATS[i], ri[i], ei);
         chk("req_ready",  LATS[i], {31'd0, rdy[i]}, {31'd0, rst_n && !wr_en});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      req_valid = 1'b1; req_addr = a;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      chk("reset resp_valid", 2, {31'd0, rv[1]}, 32'd0);
      chk("reset resp_addr", 2, ra[1], 32'd0);
      chk("reset req_ready", 2, {31'd0, rdy[1]}, 32'd0);
      rst_n = 1'b1;
      #1 chk("ready after reset", 2, {31'd0, rdy[1]}, 32'd1);

      // Preload, including one out-of-range write that must be dropped.
      wr(32'h0,  32'hA0000000);
      wr(32'h4,  32'hA1111111);
      wr(32'h8,  32'hA2222222);
      wr(32'hC,  32'hA3333333);
      wr(32'h10, 32'hDEADBEEF);
      wr(32'h14, 32'h11111111);
      wr(32'h4010, 32'hBAD0BAD0);
      repeat (2) step();

      // Single fetch: response offsets 1, 2, 4.
      rd(32'h10);
      @(negedge clk);
      chk("single L1 valid", 1, {31'd0, rv[0]}, 32'd1);
      chk("single L1 inst", 1, ri[0], 32'hDEADBEEF);
      chk("single L2 early", 2, {31'd0, rv[1]}, 32'd0);
      step();
      @(negedge clk);
      chk("single L2 valid", 2, {31'd0, rv[1]}, 32'd1);
      chk("single L2 addr", 2, ra[1], 32'h10);
      chk("single L2 inst", 2, ri[1], 32'hDEADBEEF);
      step();
      @(negedge clk);
      chk("single L2 one pulse", 2, {31'd0, rv[1]}, 32'd0);
      chk("single L2 hold", 2, ri[1], 32'hDEADBEEF);
      step();
      @(negedge clk);
      chk("single L4 valid", 4, {31'd0, rv[2]}, 32'd1);
      chk("single L4 inst", 4, ri[2], 32'hDEADBEEF);
      repeat (5) step();

      // Streaming four words on consecutive edges.
      req_valid = 1'b1;
      for (int a = 0; a < 16; a += 4) begin
         req_addr = a;
         step();
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("stream L1 addr", 1, ra[0], 32'hC);
      chk("stream L2 addr", 2, ra[1], 32'h8);
      chk("stream L4 inst", 4, ri[2], 32'hA0000000);
      repeat (6) step();

      // Write and read together: write wins, read next cycle sees new word.
      wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h22222222;
      req_valid = 1'b1; req_addr = 32'h14;
      #1 chk("wr blocks ready", 1, {31'd0, rdy[0]}, 32'd0);
      step();
      wr_en = 1'b0;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("read after write", 1, ri[0], 32'h22222222);
      repeat (5) step();

      // Out-of-range fetch, ignored byte offset, dropped write.
      rd(32'h00004000);
      @(negedge clk);
      chk("oor inst", 1, ri[0], 32'h00000013);
      chk("oor addr", 1, ra[0], 32'h00004000);
      step();
      rd(32'h13);
      rd(32'h10);
      repeat (5) step();

      // Write behind an in-flight read must not change its data.
      rd(32'h14);
      wr(32'h14, 32'h33333333);
      repeat (5) step();
      rd(32'h14);
      repeat (5) step();

      // Reset pulse with two requests in flight.
      req_valid = 1'b1; req_addr = 32'h0;
      step();
      req_addr = 32'h4;
      step();
      req_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst drop L1 valid", 1, {31'd0, rv[0]}, 32'd0);
      chk("rst drop L2 valid", 2, {31'd0, rv[1]}, 32'd0);
      chk("rst clear L2 addr", 2, ra[1], 32'd0);
      #1 rst_n = 1'b1;
      repeat (6) step();
      rd(32'h10);
      @(negedge clk);
      chk("preload survives", 1, ri[0], 32'hDEADBEEF);
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096: instruction words held (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from accept to response (legal 1..4).
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013: word returned for out-of-range addresses.
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  fetch side requests a word.
REQ-007 req_ready  out  1  responder accepts the request this cycle.
REQ-008 req_addr  in  32  byte address of the requested instruction.
REQ-009 resp_valid  out  1  one-cycle pulse: response data valid.
REQ-010 resp_addr  out  32  request address echoed with the response.
REQ-011 resp_inst  out  32  instruction word for resp_addr.
REQ-012 wr_en  in  1  preload write strobe.
REQ-013 wr_addr  in  32  byte address of the preload write.
REQ-014 wr_data  in  32  preload word.

Function
REQ-015 Accept = req_valid && req_ready at a rising edge; no other condition starts a read.
REQ-016 req_ready = rst_n && !wr_en; wr_en has priority over reads, so a cycle with wr_en high accepts no request.
REQ-017 Word index = addr[log2(MEM_WORDS)+1:2]; addr[1:0] ignored for reads and writes.
REQ-018 Out of range (addr[31:log2(MEM_WORDS)+2] != 0): read returns NOP_INST with resp_addr = req_addr; write dropped, no state change.
REQ-019 Write on wr_en updates the array at that edge; a read accepted at a later edge sees the new word.
REQ-020 Pipeline: a LATENCY-stage shift register of {valid, addr, inst}. The array is read at accept. Stage k+1 loads stage k on every edge, with no stall.
REQ-021 Request accepted at edge N -> resp_valid high for exactly the cycle after edge N+LATENCY-1 (LATENCY=1: the cycle immediately after accept).
REQ-022 Back-to-back accepts on consecutive edges SHALL yield back-to-back responses, in order; up to LATENCY requests are in flight; throughput is 1 word/cycle.
REQ-023 resp_valid has no ready/backpressure; the requester must take the response in its valid cycle or discard it by address compare.
REQ-024 While resp_valid is low, resp_addr/resp_inst hold the last response's values (0 after reset).
REQ-025 A write to an address already in flight does not change the in-flight data; the response carries the word read at accept time.
REQ-026 req_addr is sampled only at accept; changes in other cycles have no effect.

Reset
REQ-027 rst_n low asynchronously clears all pipeline valid bits, resp_valid=0, resp_addr=0, resp_inst=0, req_ready=0.
REQ-028 Requests in flight at reset assertion are discarded, with no response after deassertion.
REQ-029 Array contents are not cleared by reset; preloaded words survive.
REQ-030 First accept is possible at the first rising edge with rst_n high.

Verification
REQ-031 LATENCY=2: preload word 4 = 32'hDEADBEEF; req addr 32'h10 at edge N -> resp_valid only in the cycle after edge N+1, resp_addr=32'h10, resp_inst=32'hDEADBEEF.
REQ-032 Streaming: req 0x0,0x4,0x8,0xC on 4 consecutive edges -> 4 consecutive resp_valid cycles, addresses in order, no gaps.
REQ-033 wr_en and req_valid high together -> req_ready=0, no response from that cycle; next cycle the read returns the freshly written data.
REQ-034 MEM_WORDS=4096, req 32'h00004000 -> resp_inst=32'h00000013, resp_addr=32'h00004000.
REQ-035 Two requests in flight, rst_n pulsed low mid-cycle -> resp_valid drops immediately, no response after release, preload data intact on the next read.
REQ-036 LATENCY=1 and LATENCY=4 rerun of REQ-031/032 -> response offsets of 1 and 4 cycles respectively.
